parking_gate_arbiter: RTL and testbench

Controller that shares one barrier gate between an entry requester and an exit requester of the parking datapath. Arbitrates simultaneous requests, sequences the gate through open/hold/close, and keeps the occupancy count with full/empty flags. Sits between the lane sensors and the gate actuator and count display logic.

---
 rtl/parking_gate_arbiter.sv | 118 +++++++++++
 tb/tb_parking_gate_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_arbiter.sv
// Shared barrier-gate controller: arbitrates entry/exit requests, sequences open/hold/close, tracks occupancy.
// Define ARB_RR_EN for round-robin conflict resolution; otherwise exit has fixed priority.
module parking_gate_arbiter #(
    parameter int CAPACITY = 9,
    parameter int HOLD     = 3
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       en,
    input  logic       req_in,
    input  logic       req_out,
    output logic       gate_open,
    output logic       gate_close,
    output logic       grant_in,
    output logic       grant_out,
    output logic [3:0] count,
    output logic       full,
    output logic       empty,
    output logic [1:0] state
);

    // Handshake: req_in/req_out are levels sampled only in IDLE; a grant_x
    // pulse (one cycle) acknowledges them and the requester must then drop it.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OPEN   = 2'd1,
        HOLD_S = 2'd2,
        CLOSE  = 2'd3
    } state_t;

    localparam int            HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [3:0]    CAP       = 4'(CAPACITY);

    state_t        st;
    logic [HW-1:0] hold_cnt;
    logic          elig_in;
    logic          elig_out;
    logic          pick_in;

`ifdef ARB_RR_EN
    logic last_in;  // 1 when the most recent grant went to entry
`endif

    assign full  = (count == CAP);
    assign empty = (count == 4'd0);
    assign state = st;

    always_comb begin
        elig_in  = req_in && !full && en;
        elig_out = req_out && !empty && en;
`ifdef ARB_RR_EN
        pick_in  = elig_in && (!elig_out || !last_in);
`else
        pick_in  = elig_in && !elig_out;
`endif
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            st         <= IDLE;
            hold_cnt   <= '0;
            count      <= 4'd0;
            gate_open  <= 1'b0;
            gate_close <= 1'b0;
            grant_in   <= 1'b0;
            grant_out  <= 1'b0;
`ifdef ARB_RR_EN
            last_in    <= 1'b0;
`endif
        end else begin
            case (st)
                IDLE: begin
                    if (elig_in || elig_out) begin
                        st        <= OPEN;
                        gate_open <= 1'b1;
                        if (pick_in) begin
                            grant_in <= 1'b1;
                            count    <= count + 4'd1;
`ifdef ARB_RR_EN
                            last_in  <= 1'b1;
`endif
                        end else begin
                            grant_out <= 1'b1;
                            count     <= count - 4'd1;
`ifdef ARB_RR_EN
                            last_in   <= 1'b0;
`endif
                        end
                    end
                end
                OPEN: begin
                    grant_in  <= 1'b0;
                    grant_out <= 1'b0;
                    hold_cnt  <= '0;
                    st        <= HOLD_S;
                end
                HOLD_S: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt   <= '0;
                        gate_open  <= 1'b0;
                        gate_close <= 1'b1;
                        st         <= CLOSE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                CLOSE: begin
                    gate_close <= 1'b0;
                    st         <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Scoreboarded bench for parking_gate_arbiter at CAPACITY=3, HOLD=2; honours ARB_RR_EN like the design.
module tb_parking_gate_arbiter;

    localparam int CAPACITY = 3;
    localparam int HOLD     = 2;

    logic       clock;
    logic       clear;
    logic       en;
    logic       req_in;
    logic       req_out;
    logic       gate_open;
    logic       gate_close;
    logic       grant_in;
    logic       grant_out;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic [1:0] state;

    // expected grant events: {grant_in, grant_out, count}
    logic [5:0] exp_q[$];
    int         model_count;
    int         checks;
    int         errors;

    parking_gate_arbiter #(.CAPACITY(CAPACITY), .HOLD(HOLD)) dut (
        .clock(clock), .clear(clear), .en(en), .req_in(req_in), .req_out(req_out),
        .gate_open(gate_open), .gate_close(gate_close), .grant_in(grant_in),
        .grant_out(grant_out), .count(count), .full(full), .empty(empty), .state(state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(output bit g);
        logic [5:0] e;
        @(negedge clock);
        g = grant_in || grant_out;
        if (g) begin
            if (exp_q.size() == 0) begin
                check("unexpected_grant", {26'b0, grant_in, grant_out, count}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("grant", {26'b0, grant_in, grant_out, count}, {26'b0, e});
            end
        end
    endtask

    task automatic push_exp(input bit dir_in);
        if (dir_in) model_count++;
        else        model_count--;
        exp_q.push_back({dir_in, !dir_in, 4'(model_count)});
    endtask

    task automatic wait_grant(input int budget);
        bit g;
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick(g);
            got = g;
        end
        if (!got) check("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_wait();
        bit g;
        repeat (HOLD + 2) tick(g);
        check("idle_state", {30'b0, state}, 32'd0);
    endtask

    task automatic no_grant(input int n);
        bit g;
        int ng;
        ng = 0;
        repeat (n) begin
            tick(g);
            ng += int'(g);
        end
        check("no_grant", ng, 32'd0);
    endtask

    task automatic txn(input bit dir_in);
        if (dir_in) req_in = 1'b1;
        else        req_out = 1'b1;
        push_exp(dir_in);
        wait_grant(4);
        req_in  = 1'b0;
        req_out = 1'b0;
        idle_wait();
    endtask

    initial begin
        bit g;
        bit dir;
        checks      = 0;
        errors      = 0;
        model_count = 0;
        clear       = 1'b0;
        en          = 1'b1;
        req_in      = 1'b0;
        req_out     = 1'b0;

        // reset
        tick(g);
        tick(g);
        check("rst_count", count, 32'd0);
        check("rst_empty", empty, 32'd1);
        check("rst_full", full, 32'd0);
        check("rst_gate_open", gate_open, 32'd0);
        check("rst_gate_close", gate_close, 32'd0);
        check("rst_grants", {grant_in, grant_out}, 32'd0);
        clear = 1'b1;
        tick(g);

        // single entry with exact gate timing
        req_in = 1'b1;
        push_exp(1'b1);
        tick(g);
        check("entry_latency", g, 32'd1);
        check("open_c0", gate_open, 32'd1);
        req_in = 1'b0;
        tick(g);
        check("open_c1", {gate_open, gate_close, grant_in}, 32'b100);
        tick(g);
        check("open_c2", {gate_open, gate_close}, 32'b10);
        tick(g);
        check("close_c", {gate_open, gate_close}, 32'b01);
        tick(g);
        check("back_idle", {28'b0, state, gate_open, gate_close}, 32'd0);

        // fill and block
        txn(1'b1);
        txn(1'b1);
        check("fill_count", count, 32'd3);
        check("fill_full", full, 32'd1);
        req_in = 1'b1;
        no_grant(6);
        check("blocked_count", count, 32'd3);
        req_out = 1'b1;
        push_exp(1'b0);
        wait_grant(4);
        req_out = 1'b0;
        check("exit_at_full_full", full, 32'd0);
        push_exp(1'b1);
        wait_grant(HOLD + 6);
        req_in = 1'b0;
        idle_wait();
        check("refill_full", full, 32'd1);

        // conflict at count=1
        txn(1'b0);
        txn(1'b0);
        check("pre_conflict_count", count, 32'd1);
        req_in  = 1'b1;
        req_out = 1'b1;
`ifdef ARB_RR_EN
        push_exp(1'b1);
        push_exp(1'b0);
        push_exp(1'b1);
        wait_grant(4);
        wait_grant(HOLD + 6);
        wait_grant(HOLD + 6);
`else
        push_exp(1'b0);
        push_exp(1'b1);
        push_exp(1'b0);
        wait_grant(4);
        check("fixed_empty", empty, 32'd1);
        wait_grant(HOLD + 6);
        wait_grant(HOLD + 6);
`endif
        req_in  = 1'b0;
        req_out = 1'b0;
        idle_wait();
        check("conflict_count", count, model_count);

        // enable blocks new grants but not a transaction in flight
        en      = 1'b0;
        req_in  = 1'b1;
        req_out = 1'b1;
        no_grant(6);
        check("en_count", count, model_count);
        req_out = 1'b0;
        en      = 1'b1;
        push_exp(1'b1);
        wait_grant(4);
        req_in = 1'b0;
        tick(g);
        en = 1'b0;
        tick(g);
        tick(g);
        check("en_drop_close", gate_close, 32'd1);
        check("en_drop_count", count, model_count);
        tick(g);
        en = 1'b1;

        // reset during HOLD with count=2
        while (model_count > 1) txn(1'b0);
        while (model_count < 1) txn(1'b1);
        req_in = 1'b1;
        push_exp(1'b1);
        wait_grant(4);
        req_in = 1'b0;
        tick(g);
        check("mid_hold_count", count, 32'd2);
        clear = 1'b0;
        tick(g);
        check("mid_rst_state", {30'b0, state}, 32'd0);
        check("mid_rst_out", {count, gate_open, empty}, 32'b000001);
        clear       = 1'b1;
        model_count = 0;
        tick(g);

        // random single-sided traffic
        for (int i = 0; i < 10; i++) begin
            dir = 1'($urandom_range(0, 1));
            if (dir ? (model_count < CAPACITY) : (model_count > 0)) begin
                txn(dir);
            end else begin
                if (dir) req_in = 1'b1;
                else     req_out = 1'b1;
                no_grant(3);
                req_in  = 1'b0;
                req_out = 1'b0;
            end
            check("rand_count", count, model_count);
        end

        check("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
